// File: rtl/bsg_upstream_io_tx.sv
// I/O-side transmit stage of the BSG upstream link: serializes a captured 64-bit
// word onto two 8-bit channels over four beats, with credit-based flow control.
module bsg_upstream_io_tx #(
  parameter int CH_W    = 8,
  parameter int NUM_CH  = 2,
  parameter int CREDITS = 16,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             child_valid,
  output logic             child_ready,
  input  logic [31:0]      data_cycle_0,
  input  logic [31:0]      data_cycle_1,
  input  logic             io_token,
  output logic             io_valid_out,
  output logic [CH_W-1:0]  io_data_out_ch0,
  output logic [CH_W-1:0]  io_data_out_ch1,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] finish_cnt,
  output logic             credit_err
);

  localparam int BEAT_W = CH_W * NUM_CH;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] B0   = 3'd1;
  localparam logic [2:0] B1   = 3'd2;
  localparam logic [2:0] B2   = 3'd3;
  localparam logic [2:0] B3   = 3'd4;

  logic [2:0]        state_r;
  logic [2:0]        state_next_s;
  logic [63:0]       hold_r;
  logic [63:0]       hold_next_s;
  logic [CNT_W-1:0]  sent_r;
  logic [CNT_W-1:0]  finish_r;
  logic [CNT_W-1:0]  sent_next_s;
  logic [CNT_W-1:0]  finish_next_s;
  logic [CNT_W-1:0]  outstanding_s;
  logic              err_r;
  logic              err_next_s;
  logic              valid_r;
  logic              valid_next_s;
  logic [BEAT_W-1:0] beat_r;
  logic [BEAT_W-1:0] beat_next_s;
  logic              ready_s;
  logic              accept_s;

  // Credit accounting uses only registered counters; same-cycle tokens are not counted.
  always_comb begin
    outstanding_s = sent_r - finish_r;
    if (((state_r == IDLE) || (state_r == B3)) && (outstanding_s < CNT_W'(CREDITS))) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    accept_s = child_valid & ready_s;
  end

  // Next-state, holding register, beat selection and counter updates.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = accept_s ? B0 : IDLE;
      B0:      state_next_s = B1;
      B1:      state_next_s = B2;
      B2:      state_next_s = B3;
      B3:      state_next_s = accept_s ? B0 : IDLE;
      default: state_next_s = IDLE;
    endcase

    if (accept_s) begin
      hold_next_s = {data_cycle_1, data_cycle_0};
    end else begin
      hold_next_s = hold_r;
    end

    // Beat is chosen from the next state so the outputs can be registered.
    valid_next_s = 1'b1;
    case (state_next_s)
      B0:      beat_next_s = hold_next_s[15:0];
      B1:      beat_next_s = hold_next_s[31:16];
      B2:      beat_next_s = hold_next_s[47:32];
      B3:      beat_next_s = hold_next_s[63:48];
      default: begin
        beat_next_s  = {BEAT_W{1'b0}};
        valid_next_s = 1'b0;
      end
    endcase

    if (accept_s) begin
      sent_next_s = sent_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sent_next_s = sent_r;
    end

    if (io_token && (outstanding_s != {CNT_W{1'b0}})) begin
      finish_next_s = finish_r + {{(CNT_W-1){1'b0}}, 1'b1};
      err_next_s    = err_r;
    end else if (io_token) begin
      finish_next_s = finish_r;
      err_next_s    = 1'b1;
    end else begin
      finish_next_s = finish_r;
      err_next_s    = err_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      hold_r   <= 64'h0;
      sent_r   <= {CNT_W{1'b0}};
      finish_r <= {CNT_W{1'b0}};
      err_r    <= 1'b0;
      valid_r  <= 1'b0;
      beat_r   <= {BEAT_W{1'b0}};
    end else begin
      state_r  <= state_next_s;
      hold_r   <= hold_next_s;
      sent_r   <= sent_next_s;
      finish_r <= finish_next_s;
      err_r    <= err_next_s;
      valid_r  <= valid_next_s;
      beat_r   <= beat_next_s;
    end
  end

  assign child_ready     = ready_s;
  assign io_valid_out    = valid_r;
  assign io_data_out_ch0 = beat_r[CH_W-1:0];
  assign io_data_out_ch1 = beat_r[2*CH_W-1:CH_W];
  assign sent_cnt        = sent_r;
  assign finish_cnt      = finish_r;
  assign credit_err      = err_r;

endmodule

// File: tb/tb_bsg_upstream_io_tx.sv
// Directed bench for bsg_upstream_io_tx: a per-cycle vector table plus
// hand-written sequences for credit stall, token corners, reset and wrap.
module tb_bsg_upstream_io_tx;

  logic        clk;
  logic        rst;
  logic        child_valid;
  logic        child_ready;
  logic [31:0] data_cycle_0;
  logic [31:0] data_cycle_1;
  logic        io_token;
  logic        io_valid_out;
  logic [7:0]  io_data_out_ch0;
  logic [7:0]  io_data_out_ch1;
  logic [6:0]  sent_cnt;
  logic [6:0]  finish_cnt;
  logic        credit_err;

  int n_vec  = 0;
  int n_miss = 0;

  bsg_upstream_io_tx dut (
    .clk(clk), .rst(rst),
    .child_valid(child_valid), .child_ready(child_ready),
    .data_cycle_0(data_cycle_0), .data_cycle_1(data_cycle_1),
    .io_token(io_token), .io_valid_out(io_valid_out),
    .io_data_out_ch0(io_data_out_ch0), .io_data_out_ch1(io_data_out_ch1),
    .sent_cnt(sent_cnt), .finish_cnt(finish_cnt), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        tok;
    logic        exp_ready;
    logic        exp_v;
    logic [7:0]  exp_c0;
    logic [7:0]  exp_c1;
    logic [6:0]  exp_sent;
    logic [6:0]  exp_fin;
    logic        exp_err;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic valid, logic [31:0] d0, logic [31:0] d1, logic tok,
                              logic rdy, logic v, logic [7:0] c0, logic [7:0] c1,
                              logic [6:0] s, logic [6:0] f, logic e);
    vec_t r;
    r.valid = valid; r.d0 = d0; r.d1 = d1; r.tok = tok;
    r.exp_ready = rdy; r.exp_v = v; r.exp_c0 = c0; r.exp_c1 = c1;
    r.exp_sent = s; r.exp_fin = f; r.exp_err = e;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; child_valid = 1'b0; io_token = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_word(logic [31:0] d0, logic [31:0] d1, int bound);
    bit got = 1'b0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      child_valid = 1'b1; data_cycle_0 = d0; data_cycle_1 = d1;
      #1;
      if (child_ready) got = 1'b1;
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      n_vec++; n_miss++;
      $display("FAIL send_word timeout: no ready within %0d cycles", bound);
    end
    child_valid = 1'b0;
  endtask

  task automatic pulse_token();
    @(negedge clk);
    io_token = 1'b1;
    @(posedge clk);
    #1;
    io_token = 1'b0;
  endtask

  initial begin
    int acc;
    rst = 1'b0; child_valid = 1'b0; io_token = 1'b0;
    data_cycle_0 = 32'h0; data_cycle_1 = 32'h0;

    // Single word, then three back-to-back words with data changing while not ready.
    tbl[0]  = mk(1'b1, 32'h33221100, 32'h77665544, 1'b0, 1'b1, 1'b1, 8'h00, 8'h11, 7'd1, 7'd0, 1'b0);
    tbl[1]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h22, 8'h33, 7'd1, 7'd0, 1'b0);
    tbl[2]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h44, 8'h55, 7'd1, 7'd0, 1'b0);
    tbl[3]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h66, 8'h77, 7'd1, 7'd0, 1'b0);
    tbl[4]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 7'd1, 7'd0, 1'b0);
    tbl[5]  = mk(1'b1, 32'h04030201, 32'h08070605, 1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 7'd2, 7'd0, 1'b0);
    tbl[6]  = mk(1'b1, 32'h14131211, 32'h18171615, 1'b0, 1'b0, 1'b1, 8'h03, 8'h04, 7'd2, 7'd0, 1'b0);
    tbl[7]  = mk(1'b1, 32'h14131211, 32'h18171615, 1'b0, 1'b0, 1'b1, 8'h05, 8'h06, 7'd2, 7'd0, 1'b0);
    tbl[8]  = mk(1'b1, 32'h14131211, 32'h18171615, 1'b0, 1'b0, 1'b1, 8'h07, 8'h08, 7'd2, 7'd0, 1'b0);
    tbl[9]  = mk(1'b1, 32'h14131211, 32'h18171615, 1'b0, 1'b1, 1'b1, 8'h11, 8'h12, 7'd3, 7'd0, 1'b0);
    tbl[10] = mk(1'b1, 32'h24232221, 32'h28272625, 1'b0, 1'b0, 1'b1, 8'h13, 8'h14, 7'd3, 7'd0, 1'b0);
    tbl[11] = mk(1'b1, 32'h24232221, 32'h28272625, 1'b0, 1'b0, 1'b1, 8'h15, 8'h16, 7'd3, 7'd0, 1'b0);
    tbl[12] = mk(1'b1, 32'h24232221, 32'h28272625, 1'b0, 1'b0, 1'b1, 8'h17, 8'h18, 7'd3, 7'd0, 1'b0);
    tbl[13] = mk(1'b1, 32'h24232221, 32'h28272625, 1'b0, 1'b1, 1'b1, 8'h21, 8'h22, 7'd4, 7'd0, 1'b0);
    tbl[14] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h23, 8'h24, 7'd4, 7'd0, 1'b0);
    tbl[15] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h25, 8'h26, 7'd4, 7'd0, 1'b0);
    tbl[16] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h27, 8'h28, 7'd4, 7'd0, 1'b0);
    tbl[17] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 7'd4, 7'd0, 1'b0);
    tbl[18] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 7'd4, 7'd1, 1'b0);
    tbl[19] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 7'd4, 7'd2, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, io_valid_out}, 32'h0);
    check("rst_ch", {16'h0, io_data_out_ch1, io_data_out_ch0}, 32'h0);
    check("rst_cnt", {18'h0, sent_cnt, finish_cnt}, 32'h0);
    check("rst_err", {31'h0, credit_err}, 32'h0);
    check("rst_ready", {31'h0, child_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      child_valid = tbl[i].valid; data_cycle_0 = tbl[i].d0; data_cycle_1 = tbl[i].d1;
      io_token = tbl[i].tok;
      #1;
      check($sformatf("v%0d_ready", i), {31'h0, child_ready}, {31'h0, tbl[i].exp_ready});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'h0, io_valid_out}, {31'h0, tbl[i].exp_v});
      check($sformatf("v%0d_ch", i), {16'h0, io_data_out_ch1, io_data_out_ch0},
            {16'h0, tbl[i].exp_c1, tbl[i].exp_c0});
      check($sformatf("v%0d_cnt", i), {18'h0, sent_cnt, finish_cnt},
            {18'h0, tbl[i].exp_sent, tbl[i].exp_fin});
      check($sformatf("v%0d_err", i), {31'h0, credit_err}, {31'h0, tbl[i].exp_err});
    end
    child_valid = 1'b0; io_token = 1'b0;

    // Reset mid-train: outputs clear asynchronously, next word restarts at B0
    do_reset();
    send_word(32'hDDCCBBAA, 32'h11223344, 10);
    check("mt_b0", {16'h0, io_data_out_ch1, io_data_out_ch0}, 32'h0000BBAA);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mt_valid", {31'h0, io_valid_out}, 32'h0);
    check("mt_ch", {16'h0, io_data_out_ch1, io_data_out_ch0}, 32'h0);
    check("mt_cnt", {18'h0, sent_cnt, finish_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    send_word(32'h5A4B3C2D, 32'h0, 10);
    check("mt_new_b0", {15'h0, io_valid_out, io_data_out_ch1, io_data_out_ch0}, 32'h00013C2D);
    check("mt_new_sent", {25'h0, sent_cnt}, 32'd1);

    // Spurious token right after reset; credit_err is sticky
    do_reset();
    pulse_token();
    check("sp_fin", {25'h0, finish_cnt}, 32'd0);
    check("sp_err", {31'h0, credit_err}, 32'h1);
    send_word(32'h1, 32'h2, 10);
    repeat (4) @(posedge clk);
    pulse_token();
    check("sp_fin2", {25'h0, finish_cnt}, 32'd1);
    check("sp_err2", {31'h0, credit_err}, 32'h1);
    do_reset();
    #1;
    check("sp_err_clr", {31'h0, credit_err}, 32'h0);

    // Credit stall with producer valid held high
    acc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      child_valid = 1'b1; data_cycle_0 = 32'(c); data_cycle_1 = 32'hC0FFEE00;
      #1;
      if (child_ready) acc++;
      @(posedge clk);
    end
    #1;
    check("cs_acc", 32'(acc), 32'd16);
    check("cs_sent", {25'h0, sent_cnt}, 32'd16);
    check("cs_idle", {31'h0, io_valid_out}, 32'h0);
    @(negedge clk);
    io_token = 1'b1;
    #1;
    check("cs_ready0", {31'h0, child_ready}, 32'h0);
    @(posedge clk);
    #1;
    io_token = 1'b0;
    check("cs_fin", {25'h0, finish_cnt}, 32'd1);
    @(negedge clk);
    data_cycle_0 = 32'h17171717;
    #1;
    check("cs_ready1", {31'h0, child_ready}, 32'h1);
    @(posedge clk);
    #1;
    child_valid = 1'b0;
    check("cs_17th", {15'h0, io_valid_out, io_data_out_ch1, io_data_out_ch0}, 32'h00011717);
    check("cs_sent17", {25'h0, sent_cnt}, 32'd17);

    // Simultaneous accept and token at outstanding 15
    do_reset();
    for (int w = 0; w < 15; w++) send_word(32'(w), 32'h0, 10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    child_valid = 1'b1; io_token = 1'b1;
    #1;
    check("si_ready", {31'h0, child_ready}, 32'h1);
    @(posedge clk);
    #1;
    child_valid = 1'b0; io_token = 1'b0;
    check("si_cnt", {18'h0, sent_cnt, finish_cnt}, {18'h0, 7'd16, 7'd1});
    repeat (3) @(posedge clk);
    #1;
    check("si_out", {25'h0, 7'(sent_cnt - finish_cnt)}, 32'd15);
    check("si_ready_b3", {31'h0, child_ready}, 32'h1);

    // Counter wrap through 130 token-returned words
    do_reset();
    for (int w = 0; w < 130; w++) begin
      send_word(32'(w), ~32'(w), 20);
      repeat (4) @(posedge clk);
      pulse_token();
    end
    check("wr_cnt", {18'h0, sent_cnt, finish_cnt}, {18'h0, 7'd2, 7'd2});
    check("wr_err", {31'h0, credit_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
